conv2d_stream: RTL

Parametrised streaming 2-D convolution engine for the pattern-recognition pipeline, generalising the fixed 3x3 greyscale `convolution_filter`. It runs an odd K×K signed kernel over a raster-order pixel stream with valid/ready handshakes on both sides. It produces exactly one output pixel per input pixel, with zero padding at the borders, and flushes the frame tail internally. A runtime normalising shift and a selectable output mode (clamp or absolute value) let one instance serve blur, sharpen and edge-detect kernels.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv2d_stream_if.sv | 21 ++
 rtl/conv_line_buffer.sv | 44 ++++
 rtl/conv2d_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for conv2d_stream.
// FSM state encoding, output modes, accumulator sizing, saturation.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic OUT_CLAMP = 1'b0;
  localparam logic OUT_ABS   = 1'b1;

  function automatic int acc_width(
    input int w,
    input int kw,
    input int k
  );
    return w + kw + 1 + $clog2(k * k);
  endfunction

  // Clip a signed value into the unsigned range [0, 2^w-1].
  function automatic logic [63:0] sat_u(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] lim;
    lim = (64'sd1 <<< w) - 64'sd1;
    if (v < 0)
      return '0;
    else if (v > lim)
      return lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: valid/ready pixel stream bundle.
// master drives valid/data, slave drives ready.
interface conv2d_stream_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 circular line RAMs with a shared column pointer.
// Ports: clk, rst_n, i_en (advance), i_pix (newest), o_col (K-tall column, [K-1]=newest).
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int K         = 3,
  parameter int W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [W-1:0]        i_pix,
  output logic [K-1:0][W-1:0] o_col
);

  localparam int PW = $clog2(IMG_WIDTH);

  logic [W-1:0]  r_ram [K-1][IMG_WIDTH];
  logic [PW-1:0] r_ptr;

  // Each RAM is an exact IMG_WIDTH-step delay, so pointer phase is irrelevant.
  always_comb begin
    o_col[K-1] = i_pix;
    for (int l = 0; l < K-1; l++)
      o_col[K-2-l] = r_ram[l][r_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (i_en)
      r_ptr <= (r_ptr == PW'(IMG_WIDTH-1)) ? '0 : r_ptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_ram[0][r_ptr] <= i_pix;
      for (int l = 1; l < K-1; l++)
        r_ram[l][r_ptr] <= r_ram[l-1][r_ptr];
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK convolution, zero-padded, one output per input.
// Ports: clk, rst_n, x (pixel in), y (pixel out), kernel, cfg_shift, cfg_abs, frame_done.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int K          = 3,
  parameter int W          = 8,
  parameter int KW         = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  conv2d_stream_if.slave                    x,
  conv2d_stream_if.master                   y,
  input  logic signed [K-1:0][K-1:0][KW-1:0] kernel,
  input  logic [3:0]                        cfg_shift,
  input  logic                              cfg_abs,
  output logic                              frame_done
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int H2    = K / 2;
  localparam int P     = H2 * IMG_WIDTH + H2;
  localparam int NT    = K * K;
  localparam int PW    = W + 1 + KW;
  localparam int ACC_W = acc_width(W, KW, K);
  localparam int CNT_W = $clog2(N + P + 1);
  localparam int RW    = $clog2(IMG_HEIGHT + 1);
  localparam int CW    = $clog2(IMG_WIDTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [RW-1:0]    r_cr;
  logic [CW-1:0]    r_cc;

  logic signed [K-1:0][K-1:0][KW-1:0] r_kern;
  logic [3:0] r_shift;
  logic       r_abs;

  logic w_en;
  logic w_acc;
  logic w_inj;
  logic w_step;
  logic w_ctr;
  logic w_hs;

  logic [W-1:0]        w_pix;
  logic [K-1:0][W-1:0] w_col;
  logic [W-1:0]        r_win [K][K];

  logic          r_wv;
  logic [RW-1:0] r_wr;
  logic [CW-1:0] r_wc;

  logic signed [PW-1:0]    w_prod [NT];
  logic signed [PW-1:0]    r_prod [NT];
  logic                    r_pv;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_sum;
  logic                    r_sv;
  logic signed [ACC_W-1:0] w_sh;
  logic signed [63:0]      w_v;
  logic [W-1:0]            w_y;
  logic                    r_yv;
  logic [W-1:0]            r_yd;

  // A held output stalls the whole pipe, window and counters.
  assign w_en    = !(r_yv && !y.ready);
  assign x.ready = w_en && rst_n && (r_state != S_FLUSH);
  assign w_acc   = x.valid && x.ready;
  assign w_inj   = w_en && (r_state == S_FLUSH)
                && (r_in_cnt < CNT_W'(N + P));
  assign w_step  = w_acc || w_inj;
  assign w_pix   = w_acc ? x.data : '0;
  // Window centre lags the incoming pixel by P positions.
  assign w_ctr   = r_in_cnt >= CNT_W'(P);
  assign w_hs    = r_yv && y.ready;

  assign frame_done = w_hs && (r_out_cnt == CNT_W'(N - 1));
  assign y.valid    = r_yv;
  assign y.data     = r_yd;

  conv_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .K         (K),
    .W         (W)
  ) u_lb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_step),
    .i_pix (w_pix),
    .o_col (w_col)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_cr      <= '0;
      r_cc      <= '0;
      r_kern    <= '0;
      r_shift   <= '0;
      r_abs     <= OUT_CLAMP;
    end else begin
      if (w_step)
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      if (w_step && w_ctr) begin
        if (r_cc == CW'(IMG_WIDTH-1)) begin
          r_cc <= '0;
          r_cr <= r_cr + RW'(1);
        end else begin
          r_cc <= r_cc + CW'(1);
        end
      end
      if (w_hs)
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_RUN;
            r_kern  <= kernel;
            r_shift <= cfg_shift;
            r_abs   <= cfg_abs;
          end
        end
        S_RUN: begin
          if (w_acc && r_in_cnt == CNT_W'(N - 1))
            r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (frame_done) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_cr      <= '0;
            r_cc      <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_step) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-1] <= w_col[r];
      end
    end
  end

  // Taps outside the image read as zero; hides padding and stale RAM.
  always_comb begin
    int           tr;
    int           tc;
    logic [W-1:0] px;
    tr = 0;
    tc = 0;
    px = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        tr = int'(r_wr) + r - H2;
        tc = int'(r_wc) + c - H2;
        px = (tr >= 0 && tr < IMG_HEIGHT && tc >= 0 && tc < IMG_WIDTH)
           ? r_win[r][c] : '0;
        w_prod[r*K+c] = PW'($signed({1'b0, px}))
                      * PW'($signed(r_kern[r][c]));
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NT; i++)
      w_sum = w_sum + ACC_W'(r_prod[i]);
  end

  assign w_sh = r_sum >>> r_shift;

  always_comb begin
    w_v = 64'(w_sh);
    if (r_abs == OUT_ABS && w_v < 0)
      w_v = -w_v;
    w_y = W'(sat_u(w_v, W));
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_prod <= w_prod;
      r_sum  <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wv <= 1'b0;
      r_wr <= '0;
      r_wc <= '0;
      r_pv <= 1'b0;
      r_sv <= 1'b0;
      r_yv <= 1'b0;
      r_yd <= '0;
    end else if (w_en) begin
      r_wv <= w_step && w_ctr;
      if (w_step && w_ctr) begin
        r_wr <= r_cr;
        r_wc <= r_cc;
      end
      r_pv <= r_wv;
      r_sv <= r_pv;
      r_yv <= r_sv;
      if (r_sv)
        r_yd <= w_y;
    end
  end

endmodule
